rs_wakeup_select: RTL and testbench

Reservation station for one execution unit: holds dispatched micro-ops until both source operands are available, snoops the four CDB lanes to capture results by tag, and issues the oldest ready micro-op over a valid/ready handshake. It sits between rename/dispatch and an ALU/LSU/branch pipe, and is the receiving end of the CDB broadcast.

---
 rtl/ooo_pkg.sv | 46 ++++
 rtl/rs_age_matrix.sv | 38 +++
 rtl/rs_wakeup_select.sv | 160 ++++++++++++++++
 tb/tb_rs_wakeup_select.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: CDB geometry, station entry layout
// and the CDB tag-match helper used by every wakeup comparator.
package ooo_pkg;

  localparam int TAG_W   = 8;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 7;
  localparam int NUM_CDB = 4;
  localparam int OP_W    = 6;

  // One reservation-station slot; source 0 sits in the low index of each pair.
  typedef struct packed {
    logic                   valid;
    logic [OP_W-1:0]        op;
    logic [TAG_W-1:0]       dest_tag;
    logic [ROB_W-1:0]       rob_tag;
    logic [1:0]             src_rdy;
    logic [1:0][TAG_W-1:0]  src_tag;
    logic [1:0][DATA_W-1:0] src_data;
  } rs_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } cdb_hit_t;

  // Scan lanes from the top down so the lowest matching lane is the last
  // writer and therefore wins when several lanes carry the same tag.
  function automatic cdb_hit_t cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        lane_valid,
    input logic [NUM_CDB*TAG_W-1:0]  lane_tag,
    input logic [NUM_CDB*DATA_W-1:0] lane_data
  );
    cdb_hit_t r;
    r = '0;
    for (int l = NUM_CDB - 1; l >= 0; l--) begin
      if (lane_valid[l] && (lane_tag[l*TAG_W +: TAG_W] == tag)) begin
        r.hit  = 1'b1;
        r.data = lane_data[l*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station. Row i holds the set of entries
// that were already resident when entry i was allocated, so the oldest ready
// entry is the one whose row contains no other ready entry.
module rs_age_matrix #(
  parameter int ENTRIES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ENTRIES-1:0] alloc,
  input  logic [ENTRIES-1:0] free,
  input  logic [ENTRIES-1:0] valid,
  input  logic [ENTRIES-1:0] ready,
  output logic [ENTRIES-1:0] oldest
);

  logic [ENTRIES-1:0] older [ENTRIES];

  // A new row snapshots the survivors; a freed entry drops out of every row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc[i]) older[i] <= valid & ~free;
        else          older[i] <= older[i] & ~free;
      end
    end
  end

  // Grant the ready entry with no ready entry older than itself.
  always_comb begin
    oldest = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      oldest[i] = ready[i] & ~(|(older[i] & ready));
    end
  end

endmodule

// File: rtl/rs_wakeup_select.sv
// Reservation station for one execution unit: captures CDB results by tag,
// and issues the oldest micro-op whose two sources are both available.
module rs_wakeup_select
  import ooo_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [TAG_W-1:0]           disp_dest_tag,
  input  logic [ROB_W-1:0]           disp_rob_tag,
  input  logic [1:0]                 disp_src_rdy,
  input  logic [2*TAG_W-1:0]         disp_src_tag,
  input  logic [2*DATA_W-1:0]        disp_src_data,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [TAG_W-1:0]           iss_dest_tag,
  output logic [ROB_W-1:0]           iss_rob_tag,
  output logic [2*DATA_W-1:0]        iss_src_data,
  output logic [$clog2(ENTRIES):0]   rs_count
);

  localparam int CNT_W = $clog2(ENTRIES) + 1;

  rs_entry_t          entries      [ENTRIES];
  rs_entry_t          entries_next [ENTRIES];
  rs_entry_t          disp_entry;
  cdb_hit_t           disp_hit;
  cdb_hit_t           wake_hit;
  logic [ENTRIES-1:0] valid_vec;
  logic [ENTRIES-1:0] ready_vec;
  logic [ENTRIES-1:0] alloc_vec;
  logic [ENTRIES-1:0] free_vec;
  logic [ENTRIES-1:0] grant_vec;
  logic [CNT_W-1:0]   count;
  logic               alloc_en;
  logic               alloc_found;
  logic               issue_fire;

  // Occupancy and readiness summaries taken from registered state only.
  always_comb begin
    count     = '0;
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      ready_vec[i] = entries[i].valid & (&entries[i].src_rdy);
      count        = count + CNT_W'(entries[i].valid);
    end
  end

  assign rs_count   = count;
  assign disp_ready = (count != CNT_W'(ENTRIES));
  assign alloc_en   = disp_valid && disp_ready && !flush;
  assign iss_valid  = (|grant_vec) && !flush;
  assign issue_fire = iss_valid && iss_ready;
  assign free_vec   = issue_fire ? grant_vec : '0;

  // Dispatch goes to the lowest-index free slot.
  always_comb begin
    alloc_vec   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc_en && !alloc_found && !valid_vec[i]) begin
        alloc_vec[i] = 1'b1;
        alloc_found  = 1'b1;
      end
    end
  end

  // Build the incoming entry, catching a result broadcast in the same cycle.
  always_comb begin
    disp_entry          = '0;
    disp_hit            = '0;
    disp_entry.valid    = 1'b1;
    disp_entry.op       = disp_op;
    disp_entry.dest_tag = disp_dest_tag;
    disp_entry.rob_tag  = disp_rob_tag;
    for (int s = 0; s < 2; s++) begin
      disp_entry.src_tag[s] = disp_src_tag[s*TAG_W +: TAG_W];
      disp_hit = cdb_lookup(disp_src_tag[s*TAG_W +: TAG_W], cdb_valid, cdb_tag, cdb_data);
      if (disp_src_rdy[s]) begin
        disp_entry.src_rdy[s]  = 1'b1;
        disp_entry.src_data[s] = disp_src_data[s*DATA_W +: DATA_W];
      end else begin
        disp_entry.src_rdy[s]  = disp_hit.hit;
        disp_entry.src_data[s] = disp_hit.data;
      end
    end
  end

  // Next state per slot: flush beats everything, then allocate, issue, wakeup.
  always_comb begin
    wake_hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      entries_next[i] = entries[i];
      if (flush) begin
        entries_next[i].valid = 1'b0;
      end else if (alloc_vec[i]) begin
        entries_next[i] = disp_entry;
      end else if (free_vec[i]) begin
        entries_next[i].valid = 1'b0;
      end else if (entries[i].valid) begin
        for (int s = 0; s < 2; s++) begin
          wake_hit = cdb_lookup(entries[i].src_tag[s], cdb_valid, cdb_tag, cdb_data);
          if (!entries[i].src_rdy[s] && wake_hit.hit) begin
            entries_next[i].src_rdy[s]  = 1'b1;
            entries_next[i].src_data[s] = wake_hit.data;
          end
        end
      end
    end
  end

  // Slot storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) entries[i] <= entries_next[i];
    end
  end

  rs_age_matrix #(
    .ENTRIES (ENTRIES)
  ) u_age (
    .clk    (clk),
    .reset  (reset),
    .alloc  (alloc_vec),
    .free   (free_vec),
    .valid  (valid_vec),
    .ready  (ready_vec),
    .oldest (grant_vec)
  );

  // Present the granted slot; all zeros when nothing is ready.
  always_comb begin
    iss_op       = '0;
    iss_dest_tag = '0;
    iss_rob_tag  = '0;
    iss_src_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant_vec[i]) begin
        iss_op       = entries[i].op;
        iss_dest_tag = entries[i].dest_tag;
        iss_rob_tag  = entries[i].rob_tag;
        iss_src_data = entries[i].src_data;
      end
    end
  end

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Self-checking bench for rs_wakeup_select: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against an
// age-ordered queue model of the station.
module tb_rs_wakeup_select;
  import ooo_pkg::*;

  localparam int ENTRIES = 8;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      flush;
  logic                      disp_valid;
  logic                      disp_ready;
  logic [OP_W-1:0]           disp_op;
  logic [TAG_W-1:0]          disp_dest_tag;
  logic [ROB_W-1:0]          disp_rob_tag;
  logic [1:0]                disp_src_rdy;
  logic [2*TAG_W-1:0]        disp_src_tag;
  logic [2*DATA_W-1:0]       disp_src_data;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      iss_valid;
  logic                      iss_ready;
  logic [OP_W-1:0]           iss_op;
  logic [TAG_W-1:0]          iss_dest_tag;
  logic [ROB_W-1:0]          iss_rob_tag;
  logic [2*DATA_W-1:0]       iss_src_data;
  logic [$clog2(ENTRIES):0]  rs_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_wakeup_select #(.ENTRIES(ENTRIES)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_op       (disp_op),
    .disp_dest_tag (disp_dest_tag),
    .disp_rob_tag  (disp_rob_tag),
    .disp_src_rdy  (disp_src_rdy),
    .disp_src_tag  (disp_src_tag),
    .disp_src_data (disp_src_data),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_op        (iss_op),
    .iss_dest_tag  (iss_dest_tag),
    .iss_rob_tag   (iss_rob_tag),
    .iss_src_data  (iss_src_data),
    .rs_count      (rs_count)
  );

  // Model: resident micro-ops in dispatch order, index 0 = oldest.
  typedef struct packed {
    logic [OP_W-1:0]        op;
    logic [TAG_W-1:0]       dest;
    logic [ROB_W-1:0]       rob;
    logic [1:0]             rdy;
    logic [1:0][TAG_W-1:0]  tag;
    logic [1:0][DATA_W-1:0] data;
  } mdl_entry_t;

  mdl_entry_t model_q[$];

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First lane (in lane order) carrying the tag supplies the value.
  function automatic logic laneLookup(input logic [TAG_W-1:0] tag, output logic [DATA_W-1:0] d);
    d = '0;
    for (int l = 0; l < NUM_CDB; l++) begin
      if (cdb_valid[l] && cdb_tag[l*TAG_W +: TAG_W] == tag) begin
        d = cdb_data[l*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int modelOldestReady();
    for (int i = 0; i < model_q.size(); i++) begin
      if (model_q[i].rdy == 2'b11) return i;
    end
    return -1;
  endfunction

  // Advance the model on each clock edge from the inputs present at that edge.
  always @(posedge clk or posedge reset) begin
    int                sel;
    logic              fire;
    logic              accept;
    mdl_entry_t        e;
    logic [DATA_W-1:0] d;
    if (reset) begin
      model_q.delete();
    end else begin
      sel    = modelOldestReady();
      fire   = (sel >= 0) && !flush && iss_ready;
      accept = disp_valid && (model_q.size() < ENTRIES) && !flush;
      if (flush) begin
        model_q.delete();
      end else begin
        for (int i = 0; i < model_q.size(); i++) begin
          e = model_q[i];
          for (int s = 0; s < 2; s++) begin
            if (!e.rdy[s] && laneLookup(e.tag[s], d)) begin
              e.rdy[s]  = 1'b1;
              e.data[s] = d;
            end
          end
          model_q[i] = e;
        end
        if (fire) model_q.delete(sel);
        if (accept) begin
          e.op   = disp_op;
          e.dest = disp_dest_tag;
          e.rob  = disp_rob_tag;
          for (int s = 0; s < 2; s++) begin
            e.tag[s] = disp_src_tag[s*TAG_W +: TAG_W];
            if (disp_src_rdy[s]) begin
              e.rdy[s]  = 1'b1;
              e.data[s] = disp_src_data[s*DATA_W +: DATA_W];
            end else begin
              e.rdy[s] = laneLookup(e.tag[s], d);
              e.data[s] = e.rdy[s] ? d : '0;
            end
          end
          model_q.push_back(e);
        end
      end
    end
  end

  task automatic checkOutput();
    int sel;
    if (reset) begin
      checkValue("rst_rs_count", 64'(rs_count), 64'(0));
      checkValue("rst_disp_ready", 64'(disp_ready), 64'(1));
      checkValue("rst_iss_valid", 64'(iss_valid), 64'(0));
      return;
    end
    sel = modelOldestReady();
    checkValue("mdl_rs_count", 64'(rs_count), 64'(model_q.size()));
    checkValue("mdl_disp_ready", 64'(disp_ready), 64'(model_q.size() < ENTRIES));
    checkValue("mdl_iss_valid", 64'(iss_valid), 64'((sel >= 0) && !flush));
    if ((sel >= 0) && !flush) begin
      checkValue("mdl_iss_op", 64'(iss_op), 64'(model_q[sel].op));
      checkValue("mdl_iss_dest", 64'(iss_dest_tag), 64'(model_q[sel].dest));
      checkValue("mdl_iss_rob", 64'(iss_rob_tag), 64'(model_q[sel].rob));
      checkValue("mdl_iss_src_data", iss_src_data, 64'(model_q[sel].data));
    end
  endtask

  // Compare away from the active edge, once per cycle.
  always @(negedge clk) checkOutput();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    flush         = 1'b0;
    disp_valid    = 1'b0;
    disp_op       = '0;
    disp_dest_tag = '0;
    disp_rob_tag  = '0;
    disp_src_rdy  = '0;
    disp_src_tag  = '0;
    disp_src_data = '0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    cdb_data      = '0;
    iss_ready     = 1'b0;
  endtask

  task automatic dispatchOp(input logic [OP_W-1:0] op, input logic [1:0] rdy,
                            input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                            input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    disp_valid    = 1'b1;
    disp_op       = op;
    disp_dest_tag = TAG_W'(op) + 8'h40;
    disp_rob_tag  = ROB_W'(op);
    disp_src_rdy  = rdy;
    disp_src_tag  = {t1, t0};
    disp_src_data = {d1, d0};
  endtask

  task automatic cdbLane(input int lane, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid[lane]                  = 1'b1;
    cdb_tag[lane*TAG_W +: TAG_W]     = tag;
    cdb_data[lane*DATA_W +: DATA_W]  = data;
  endtask

  task automatic applyStimulus();
    disp_valid    = ($urandom_range(0, 99) < 55);
    disp_op       = OP_W'($urandom);
    disp_dest_tag = TAG_W'($urandom);
    disp_rob_tag  = ROB_W'($urandom);
    disp_src_rdy  = 2'($urandom);
    disp_src_tag  = {TAG_W'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 15))};
    disp_src_data = {$urandom, $urandom};
    for (int l = 0; l < NUM_CDB; l++) begin
      cdb_valid[l]                 = ($urandom_range(0, 99) < 30);
      cdb_tag[l*TAG_W +: TAG_W]    = TAG_W'($urandom_range(0, 15));
      cdb_data[l*DATA_W +: DATA_W] = $urandom;
    end
    iss_ready = ($urandom_range(0, 99) < 65);
    flush     = ($urandom_range(0, 99) < 2);
    step();
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_iss_valid", 64'(iss_valid), 64'(0));
    checkValue("reset_disp_ready", 64'(disp_ready), 64'(1));
    checkValue("reset_rs_count", 64'(rs_count), 64'(0));
    checkValue("reset_iss_op", 64'(iss_op), 64'(0));
    checkValue("reset_iss_src_data", iss_src_data, 64'(0));
    reset = 1'b0;

    $display("[TB] both-ready dispatch issues next cycle");
    dispatchOp(6'h01, 2'b11, 8'h00, 8'h00, 32'h10, 32'h20);
    iss_ready = 1'b1;
    step();
    idleInputs();
    iss_ready = 1'b1;
    checkValue("t1_iss_valid", 64'(iss_valid), 64'(1));
    checkValue("t1_iss_op", 64'(iss_op), 64'(1));
    checkValue("t1_src_data", iss_src_data, 64'h00000020_00000010);
    step();
    checkValue("t1_count_after", 64'(rs_count), 64'(0));

    $display("[TB] CDB lane 2 wakeup");
    idleInputs();
    dispatchOp(6'h02, 2'b10, 8'h05, 8'h00, 32'h0, 32'h22);
    step();
    idleInputs();
    checkValue("t2_wait_valid", 64'(iss_valid), 64'(0));
    step();
    idleInputs();
    cdbLane(2, 8'h05, 32'hDEADBEEF);
    checkValue("t2_pre_wake_valid", 64'(iss_valid), 64'(0));
    step();
    idleInputs();
    iss_ready = 1'b1;
    checkValue("t2_iss_valid", 64'(iss_valid), 64'(1));
    checkValue("t2_src_data", iss_src_data, 64'h00000022_DEADBEEF);
    step();
    checkValue("t2_count_after", 64'(rs_count), 64'(0));

    $display("[TB] dispatch bypass from lane 0");
    idleInputs();
    dispatchOp(6'h03, 2'b10, 8'h07, 8'h00, 32'h0, 32'h33);
    cdbLane(0, 8'h07, 32'h12345678);
    step();
    idleInputs();
    iss_ready = 1'b1;
    checkValue("t3_iss_valid", 64'(iss_valid), 64'(1));
    checkValue("t3_src_data", iss_src_data, 64'h00000033_12345678);
    step();
    checkValue("t3_count_after", 64'(rs_count), 64'(0));

    $display("[TB] age ordering");
    idleInputs();
    dispatchOp(6'h0A, 2'b10, 8'h09, 8'h00, 32'h0, 32'hA1);
    step();
    idleInputs();
    dispatchOp(6'h0B, 2'b11, 8'h00, 8'h00, 32'hB0, 32'hB1);
    step();
    idleInputs();
    checkValue("t4_b_first", 64'(iss_op), 64'(6'h0B));
    checkValue("t4_count2", 64'(rs_count), 64'(2));
    cdbLane(1, 8'h09, 32'hA0);
    step();
    idleInputs();
    checkValue("t4_a_older", 64'(iss_op), 64'(6'h0A));
    checkValue("t4_a_data", iss_src_data, 64'h000000A1_000000A0);
    iss_ready = 1'b1;
    step();
    idleInputs();
    checkValue("t4_b_next", 64'(iss_op), 64'(6'h0B));
    iss_ready = 1'b1;
    step();
    checkValue("t4_count0", 64'(rs_count), 64'(0));

    $display("[TB] fill to capacity");
    for (int i = 0; i < ENTRIES; i++) begin
      idleInputs();
      dispatchOp(OP_W'(6'h10 + i), 2'b10, TAG_W'(8'h30 + i), 8'h00, 32'h0, DATA_W'(i));
      step();
    end
    idleInputs();
    checkValue("t5_full_ready", 64'(disp_ready), 64'(0));
    checkValue("t5_full_count", 64'(rs_count), 64'(8));
    dispatchOp(6'h3F, 2'b11, 8'h00, 8'h00, 32'h1, 32'h2);
    cdbLane(0, 8'h30, 32'hC0);
    step();
    idleInputs();
    checkValue("t5_drop_count", 64'(rs_count), 64'(8));
    checkValue("t5_woken_op", 64'(iss_op), 64'(6'h10));
    iss_ready = 1'b1;
    checkValue("t5_same_cycle_ready", 64'(disp_ready), 64'(0));
    step();
    idleInputs();
    checkValue("t5_reopen_ready", 64'(disp_ready), 64'(1));
    checkValue("t5_reopen_count", 64'(rs_count), 64'(7));
    flush = 1'b1;
    step();
    idleInputs();
    checkValue("t5_flushed", 64'(rs_count), 64'(0));

    $display("[TB] flush with held issue");
    for (int i = 0; i < 3; i++) begin
      idleInputs();
      dispatchOp(OP_W'(6'h21 + i), 2'b11, 8'h00, 8'h00, DATA_W'(i), DATA_W'(i + 1));
      step();
    end
    idleInputs();
    checkValue("t6_held_valid", 64'(iss_valid), 64'(1));
    checkValue("t6_held_op", 64'(iss_op), 64'(6'h21));
    checkValue("t6_count3", 64'(rs_count), 64'(3));
    flush = 1'b1;
    dispatchOp(6'h2F, 2'b11, 8'h00, 8'h00, 32'h5, 32'h6);
    #1;
    checkValue("t6_flush_iss", 64'(iss_valid), 64'(0));
    @(posedge clk);
    #1;
    idleInputs();
    checkValue("t6_count0", 64'(rs_count), 64'(0));
    checkValue("t6_disp_ready", 64'(disp_ready), 64'(1));

    $display("[TB] asynchronous reset mid-operation");
    dispatchOp(6'h31, 2'b11, 8'h00, 8'h00, 32'h1, 32'h2);
    step();
    dispatchOp(6'h32, 2'b11, 8'h00, 8'h00, 32'h3, 32'h4);
    step();
    idleInputs();
    #2;
    reset = 1'b1;
    #1;
    checkValue("t7_async_count", 64'(rs_count), 64'(0));
    checkValue("t7_async_valid", 64'(iss_valid), 64'(0));
    #2;
    reset = 1'b0;
    dispatchOp(6'h24, 2'b11, 8'h00, 8'h00, 32'h7, 32'h8);
    step();
    idleInputs();
    checkValue("t7_first_disp_count", 64'(rs_count), 64'(1));
    checkValue("t7_first_disp_op", 64'(iss_op), 64'(6'h24));
    iss_ready = 1'b1;
    step();

    $display("[TB] randomized traffic");
    repeat (4000) applyStimulus();
    idleInputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
